// File: rtl/window33_pkg.sv
// Shared constants for the 3x3 window generator: default pixel width,
// tap indices (row-major, top-left to bottom-right) and counter sizing.
package window33_pkg;

    localparam int DEFAULT_BIT_WIDTH = 6;

    localparam int TAP_TL     = 0;
    localparam int TAP_TC     = 1;
    localparam int TAP_TR     = 2;
    localparam int TAP_ML     = 3;
    localparam int TAP_CENTRE = 4;
    localparam int TAP_MR     = 5;
    localparam int TAP_BL     = 6;
    localparam int TAP_BC     = 7;
    localparam int TAP_BR     = 8;
    localparam int NUM_TAPS   = 9;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/row_linebuf.sv
// One image row of delay: a DEPTH-stage pixel shift register that advances
// only on shift_en, so q is the pixel accepted DEPTH accepts earlier.
module row_linebuf
    import window33_pkg::*;
#(
    parameter int DEPTH     = 5,
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [BIT_WIDTH-1:0] d,
    output logic [BIT_WIDTH-1:0] q
);

    logic [BIT_WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (shift_en) begin
            stage_reg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/window33_linebuf.sv
// Streaming 3x3 window generator with two row line buffers and no padding.
// Optional WINDOW33_WIN_COUNT_EN adds a saturating 16-bit window counter port.
module window33_linebuf
    import window33_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int IMG_W     = 5,
    parameter int IMG_H     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_pixel,
    output logic [BIT_WIDTH-1:0] win_0,
    output logic [BIT_WIDTH-1:0] win_1,
    output logic [BIT_WIDTH-1:0] win_2,
    output logic [BIT_WIDTH-1:0] win_3,
    output logic [BIT_WIDTH-1:0] win_4,
    output logic [BIT_WIDTH-1:0] win_5,
    output logic [BIT_WIDTH-1:0] win_6,
    output logic [BIT_WIDTH-1:0] win_7,
    output logic [BIT_WIDTH-1:0] win_8,
    output logic                 win_valid,
    output logic                 frame_done
`ifdef WINDOW33_WIN_COUNT_EN
    ,
    output logic [15:0]          win_count
`endif
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    logic                 accept;
    logic [COL_W-1:0]     col_reg, col_next;
    logic [ROW_W-1:0]     row_reg, row_next;
    logic                 col_last, row_last, in_window;
    logic                 win_valid_reg, frame_done_reg;
    logic [BIT_WIDTH-1:0] lb0_q, lb1_q;
    logic [BIT_WIDTH-1:0] win_reg [NUM_TAPS];
    logic [BIT_WIDTH-1:0] new_col [3];

    assign accept    = en && in_valid;
    assign col_last  = (col_reg == COL_W'(IMG_W - 1));
    assign row_last  = (row_reg == ROW_W'(IMG_H - 1));
    assign in_window = (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

    always_comb begin
        col_next = col_reg + COL_W'(1);
        row_next = row_reg;
        if (col_last) begin
            col_next = '0;
            row_next = row_last ? '0 : row_reg + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else if (accept) begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            win_valid_reg  <= in_window;
            frame_done_reg <= col_last && row_last;
        end else begin
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end
    end

    row_linebuf #(.DEPTH(IMG_W), .BIT_WIDTH(BIT_WIDTH)) lb0 (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .d        (in_pixel),
        .q        (lb0_q)
    );

    row_linebuf #(.DEPTH(IMG_W), .BIT_WIDTH(BIT_WIDTH)) lb1 (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .d        (lb0_q),
        .q        (lb1_q)
    );

    // Incoming right-hand column, top to bottom: two rows up, one row up, current.
    assign new_col[0] = lb1_q;
    assign new_col[1] = lb0_q;
    assign new_col[2] = in_pixel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                win_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_reg[3*r]     <= win_reg[3*r + 1];
                win_reg[3*r + 1] <= win_reg[3*r + 2];
                win_reg[3*r + 2] <= new_col[r];
            end
        end
    end

`ifdef WINDOW33_WIN_COUNT_EN
    logic [15:0] win_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_count_reg <= '0;
        end else if (accept && in_window && (win_count_reg != 16'hFFFF)) begin
            win_count_reg <= win_count_reg + 16'd1;
        end
    end

    assign win_count = win_count_reg;
`endif

    assign win_0      = win_reg[TAP_TL];
    assign win_1      = win_reg[TAP_TC];
    assign win_2      = win_reg[TAP_TR];
    assign win_3      = win_reg[TAP_ML];
    assign win_4      = win_reg[TAP_CENTRE];
    assign win_5      = win_reg[TAP_MR];
    assign win_6      = win_reg[TAP_BL];
    assign win_7      = win_reg[TAP_BC];
    assign win_8      = win_reg[TAP_BR];
    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_window33_linebuf.sv
// Directed bench for window33_linebuf on a 5x5 image: full frame, stalls,
// async reset mid-frame and back-to-back frames (plus win_count if enabled).
module tb_window33_linebuf;

    localparam int BW = 6;
    localparam int W  = 5;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic [BW-1:0] in_pixel;
    logic [BW-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    logic          win_valid;
    logic          frame_done;
`ifdef WINDOW33_WIN_COUNT_EN
    logic [15:0]   win_count;
`endif
    logic [9*BW-1:0] taps;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [9*BW-1:0] win_q[$];
    bit              fd_q[$];
    int              fd_total = 0;

    always #5 clk = ~clk;

    window33_linebuf #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .win_0      (win_0),
        .win_1      (win_1),
        .win_2      (win_2),
        .win_3      (win_3),
        .win_4      (win_4),
        .win_5      (win_5),
        .win_6      (win_6),
        .win_7      (win_7),
        .win_8      (win_8),
        .win_valid  (win_valid),
        .frame_done (frame_done)
`ifdef WINDOW33_WIN_COUNT_EN
        ,
        .win_count  (win_count)
`endif
    );

    assign taps = {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};

    always @(negedge clk) begin
        if (win_valid) begin
            win_q.push_back(taps);
            fd_q.push_back(frame_done);
        end
        if (frame_done) fd_total++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Window k (0..8) of a frame starting at pixel value base: top-left at (k/3, k%3).
    function automatic logic [9*BW-1:0] exp_win(input int base, input int k);
        logic [9*BW-1:0] acc;
        int              v;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v   = base + (k / 3 + i) * W + (k % 3 + j);
                acc = {acc[8*BW-1:0], v[BW-1:0]};
            end
        end
        return acc;
    endfunction

    task automatic send(input int v);
        en       = 1'b1;
        in_valid = 1'b1;
        in_pixel = v[BW-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic stall(input int n, input bit use_en);
        for (int i = 0; i < n; i++) begin
            if (use_en) begin
                en       = 1'b0;
                in_valid = 1'b1;
                in_pixel = 6'h3F;
            end else begin
                en       = 1'b1;
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check_val(use_en ? "stall_en_valid" : "stall_iv_valid", 64'(win_valid), 64'd0);
        end
        en       = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        win_q.delete();
        fd_q.delete();
        fd_total = 0;
    endtask

    task automatic verify_windows(input string tag, input int base0, input int base1, input int nframes);
        int base;
        check_val({tag, "_count"}, 64'(win_q.size()), 64'(9 * nframes));
        for (int idx = 0; idx < win_q.size() && idx < 9 * nframes; idx++) begin
            base = (idx < 9) ? base0 : base1;
            $display("%s window %0d taps %0h frame_done %0d", tag, idx, win_q[idx], fd_q[idx]);
            check_val($sformatf("%s_win%0d", tag, idx), 64'(win_q[idx]), 64'(exp_win(base, idx % 9)));
            check_val($sformatf("%s_fd%0d", tag, idx), 64'(fd_q[idx]), 64'((idx % 9) == 8));
        end
        check_val({tag, "_fd_total"}, 64'(fd_total), 64'(nframes));
    endtask

    initial begin
        logic [9*BW-1:0] hand;
        rst      = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        #1;
        check_val("reset_valid", 64'(win_valid), 64'd0);
        check_val("reset_fd", 64'(frame_done), 64'd0);
        check_val("reset_taps", 64'(taps), 64'd0);
        do_reset();

        // Full frame, one pixel per cycle; valid only for r>=2, c>=2.
        for (int p = 0; p < W * H; p++) begin
            send(p);
            check_val($sformatf("valid_p%0d", p), 64'(win_valid),
                      64'(((p / W) >= 2) && ((p % W) >= 2)));
            if (p == 12) begin
                hand = {6'd0, 6'd1, 6'd2, 6'd5, 6'd6, 6'd7, 6'd10, 6'd11, 6'd12};
                check_val("first_win", 64'(taps), 64'(hand));
            end
            if (p == 17) begin
                hand = {6'd5, 6'd6, 6'd7, 6'd10, 6'd11, 6'd12, 6'd15, 6'd16, 6'd17};
                check_val("row_wrap_win", 64'(taps), 64'(hand));
            end
        end
        check_val("last_fd", 64'(frame_done), 64'd1);
        hand = {6'd12, 6'd13, 6'd14, 6'd17, 6'd18, 6'd19, 6'd22, 6'd23, 6'd24};
        check_val("last_win", 64'(taps), 64'(hand));
        @(posedge clk);
        #1;
        check_val("idle_valid", 64'(win_valid), 64'd0);
        check_val("idle_fd", 64'(frame_done), 64'd0);
        check_val("idle_hold", 64'(taps), 64'(hand));
        verify_windows("t1", 0, 0, 1);

        // Same stream with in_valid gaps and an en=0 stall mid-row.
        do_reset();
        for (int p = 0; p < W * H; p++) begin
            send(p);
            if (p % 4 == 3) stall(3, 1'b0);
            if (p == 12) stall(2, 1'b1);
        end
        stall(1, 1'b0);
        verify_windows("t2", 0, 0, 1);

        // Asynchronous reset between edges after pixel 8.
        do_reset();
        for (int p = 0; p <= 8; p++) send(p);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_valid", 64'(win_valid), 64'd0);
        check_val("arst_fd", 64'(frame_done), 64'd0);
        check_val("arst_taps", 64'(taps), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        win_q.delete();
        fd_q.delete();
        fd_total = 0;
        for (int p = 0; p < W * H; p++) send(p);
        stall(1, 1'b0);
        verify_windows("t3", 0, 0, 1);

        // Two frames back to back.
        do_reset();
        for (int p = 0; p < W * H; p++) send(p);
        for (int p = 32; p < 32 + W * H; p++) send(p);
        stall(1, 1'b0);
        verify_windows("t4", 0, 32, 2);
        if (win_q.size() > 9) begin
            hand = {6'd32, 6'd33, 6'd34, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd44};
            check_val("f2_first_win", 64'(win_q[9]), 64'(hand));
        end else begin
            check_val("f2_first_win_present", 64'(win_q.size()), 64'd18);
        end
`ifdef WINDOW33_WIN_COUNT_EN
        check_val("win_count_18", 64'(win_count), 64'd18);
        rst = 1'b0;
        #1;
        check_val("win_count_rst", 64'(win_count), 64'd0);
        #2;
        rst = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
